// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/write-back
// and drives datapath enables per state. Instruction and data accesses share one
// bus port with a ready handshake and an optional wait timeout.
// Optional feature macro: BRANCH_EXT_EN adds BLT/BGE/BLTU/BGEU branch decode
// (outputs BranchLT, BranchGE, BranchUns).
module multicycle_control_unit #(
  parameter int ALUOP_W     = 3,
  parameter int IMMSEL_W    = 3,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opCode,
  input  logic [2:0]          funct,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCSrc,
  output logic                IRWrite,
  output logic                HADDR_Sel,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [IMMSEL_W-1:0] immediateSel,
  output logic                BranchEQ,
  output logic                BranchNE,
`ifdef BRANCH_EXT_EN
  output logic                BranchLT,
  output logic                BranchGE,
  output logic                BranchUns,
`endif
  output logic                instr_done,
  output logic                trap,
  output logic                bus_err
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b010);

  localparam logic [IMMSEL_W-1:0] IMM_I = IMMSEL_W'(3'b000);
  localparam logic [IMMSEL_W-1:0] IMM_S = IMMSEL_W'(3'b001);
  localparam logic [IMMSEL_W-1:0] IMM_B = IMMSEL_W'(3'b010);
  localparam logic [IMMSEL_W-1:0] IMM_J = IMMSEL_W'(3'b100);
  localparam logic [IMMSEL_W-1:0] IMM_U = IMMSEL_W'(3'b101);

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RD1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    AUIPC_ST,
    ALU_WB,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    BRANCH,
    JAL_ST,
    JALR_ADDR,
    JALR_WB,
    TRAP
  } stateT;

  stateT           state;
  logic [TO_W-1:0] waitCnt;
  logic [TO_W-1:0] waitNext;
  logic            busErr;
  logic            timeoutHit;
  logic            branchLegal;

  // A wait expires when the counter has reached the limit and the bus is still not ready;
  // a ready in that same cycle takes priority and completes the access normally.
  assign timeoutHit = (MEM_TIMEOUT != 0) && (waitCnt == TO_W'(MEM_TIMEOUT)) && !mem_ready;

  // Saturate rather than wrap so a disabled timeout never sees a spurious small count.
  assign waitNext = (waitCnt == '1) ? waitCnt : waitCnt + TO_W'(1);

  // Classify funct3 of a conditional branch as supported or illegal for this build.
  always_comb begin
    branchLegal = 1'b0;
    case (funct)
      3'b000, 3'b001: branchLegal = 1'b1;
`ifdef BRANCH_EXT_EN
      3'b100, 3'b101, 3'b110, 3'b111: branchLegal = 1'b1;
`endif
      default: branchLegal = 1'b0;
    endcase
  end

  // State sequencing, bus wait counting and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= FETCH;
      waitCnt <= '0;
      busErr  <= 1'b0;
    end else begin
      waitCnt <= '0;
      case (state)
        FETCH: begin
          if (mem_ready) begin
            state <= DECODE;
          end else if (timeoutHit) begin
            state  <= TRAP;
            busErr <= 1'b1;
          end else begin
            waitCnt <= waitNext;
          end
        end
        DECODE: begin
          case (opCode)
            OP_RTYPE:          state <= EXEC_R;
            OP_ITYPE:          state <= EXEC_I;
            OP_LOAD, OP_STORE: state <= MEM_ADDR;
            OP_BRANCH:         state <= branchLegal ? BRANCH : TRAP;
            OP_JAL:            state <= JAL_ST;
            OP_JALR:           state <= JALR_ADDR;
            OP_AUIPC:          state <= AUIPC_ST;
            default:           state <= TRAP;
          endcase
        end
        EXEC_R, EXEC_I, AUIPC_ST: begin
          state <= ALU_WB;
        end
        MEM_ADDR: begin
          state <= (opCode == OP_STORE) ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          if (mem_ready) begin
            state <= MEM_WB;
          end else if (timeoutHit) begin
            state  <= TRAP;
            busErr <= 1'b1;
          end else begin
            waitCnt <= waitNext;
          end
        end
        MEM_WR: begin
          if (mem_ready) begin
            state <= FETCH;
          end else if (timeoutHit) begin
            state  <= TRAP;
            busErr <= 1'b1;
          end else begin
            waitCnt <= waitNext;
          end
        end
        JALR_ADDR: begin
          state <= JALR_WB;
        end
        ALU_WB, MEM_WB, BRANCH, JAL_ST, JALR_WB: begin
          state <= FETCH;
        end
        TRAP: begin
          state <= TRAP;
        end
        default: begin
          state <= TRAP;
        end
      endcase
    end
  end

  // Decode datapath controls from the current state; everything is held low during reset.
  always_comb begin
    PCWrite      = 1'b0;
    PCSrc        = 1'b0;
    IRWrite      = 1'b0;
    HADDR_Sel    = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RD2;
    ALUOp        = ALU_ADD;
    immediateSel = IMM_I;
    BranchEQ     = 1'b0;
    BranchNE     = 1'b0;
`ifdef BRANCH_EXT_EN
    BranchLT     = 1'b0;
    BranchGE     = 1'b0;
    BranchUns    = 1'b0;
`endif
    instr_done   = 1'b0;
    trap         = 1'b0;
    bus_err      = 1'b0;
    if (rst) begin
      bus_err = busErr;
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcA = SRCA_PC;
          ALUSrcB = SRCB_FOUR;
          ALUOp   = ALU_ADD;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE: begin
          ALUSrcA      = SRCA_OLDPC;
          ALUSrcB      = SRCB_IMM;
          ALUOp        = ALU_ADD;
          immediateSel = (opCode == OP_JAL) ? IMM_J : IMM_B;
        end
        EXEC_R: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_RD2;
          ALUOp   = ALU_FUNCT;
        end
        EXEC_I: begin
          ALUSrcA      = SRCA_RD1;
          ALUSrcB      = SRCB_IMM;
          ALUOp        = ALU_FUNCT;
          immediateSel = IMM_I;
        end
        AUIPC_ST: begin
          ALUSrcA      = SRCA_OLDPC;
          ALUSrcB      = SRCB_IMM;
          ALUOp        = ALU_ADD;
          immediateSel = IMM_U;
        end
        ALU_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        MEM_ADDR: begin
          ALUSrcA      = SRCA_RD1;
          ALUSrcB      = SRCB_IMM;
          ALUOp        = ALU_ADD;
          immediateSel = (opCode == OP_STORE) ? IMM_S : IMM_I;
        end
        MEM_RD: begin
          MemRead   = 1'b1;
          HADDR_Sel = 1'b1;
        end
        MEM_WB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        MEM_WR: begin
          MemWrite   = 1'b1;
          HADDR_Sel  = 1'b1;
          instr_done = mem_ready;
        end
        BRANCH: begin
          ALUSrcA    = SRCA_RD1;
          ALUSrcB    = SRCB_RD2;
          ALUOp      = ALU_SUB;
          PCSrc      = 1'b1;
          BranchEQ   = (funct == 3'b000);
          BranchNE   = (funct == 3'b001);
`ifdef BRANCH_EXT_EN
          BranchLT   = (funct == 3'b100) || (funct == 3'b110);
          BranchGE   = (funct == 3'b101) || (funct == 3'b111);
          BranchUns  = (funct == 3'b110) || (funct == 3'b111);
`endif
          instr_done = 1'b1;
        end
        JAL_ST, JALR_WB: begin
          ALUSrcA    = SRCA_OLDPC;
          ALUSrcB    = SRCB_FOUR;
          ALUOp      = ALU_ADD;
          RegWrite   = 1'b1;
          PCWrite    = 1'b1;
          PCSrc      = 1'b1;
          instr_done = 1'b1;
        end
        JALR_ADDR: begin
          ALUSrcA      = SRCA_RD1;
          ALUSrcB      = SRCB_IMM;
          ALUOp        = ALU_ADD;
          immediateSel = IMM_I;
        end
        TRAP: begin
          trap = 1'b1;
        end
        default: begin
          trap = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: each stimulus cycle pushes the
// expected control word, and a monitor pops and compares on the falling edge.
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b0000000;

  typedef enum {
    S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_AUIPC, S_ALU_WB, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_JALR_ADDR, S_JALR_WB, S_TRAP
  } tbStateT;

  typedef struct packed {
    logic       PCWrite;
    logic       PCSrc;
    logic       IRWrite;
    logic       HADDR_Sel;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       RegWrite;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [2:0] immSel;
    logic       BranchEQ;
    logic       BranchNE;
    logic       instrDone;
    logic       trap;
    logic       busErr;
  } outVecT;

  typedef struct {
    string  name;
    outVecT exp;
  } expItemT;

  logic       clk;
  logic       rst;
  logic [6:0] opCode;
  logic [2:0] funct;
  logic       memReady;
  logic       PCWrite, PCSrc, IRWrite, HADDR_Sel, MemRead, MemWrite, MemtoReg, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB;
  logic [2:0] ALUOp, immediateSel;
  logic       BranchEQ, BranchNE, instrDone, trap, busErr;
`ifdef BRANCH_EXT_EN
  logic       BranchLT, BranchGE, BranchUns;
`endif

  outVecT  actOut;
  expItemT scoreQ[$];
  int      compared = 0;
  int      mismatched = 0;

  multicycle_control_unit #(
    .ALUOP_W(3),
    .IMMSEL_W(3),
    .MEM_TIMEOUT(4),
    .TO_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .opCode(opCode),
    .funct(funct),
    .mem_ready(memReady),
    .PCWrite(PCWrite),
    .PCSrc(PCSrc),
    .IRWrite(IRWrite),
    .HADDR_Sel(HADDR_Sel),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .MemtoReg(MemtoReg),
    .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp),
    .immediateSel(immediateSel),
    .BranchEQ(BranchEQ),
    .BranchNE(BranchNE),
`ifdef BRANCH_EXT_EN
    .BranchLT(BranchLT),
    .BranchGE(BranchGE),
    .BranchUns(BranchUns),
`endif
    .instr_done(instrDone),
    .trap(trap),
    .bus_err(busErr)
  );

  assign actOut = {PCWrite, PCSrc, IRWrite, HADDR_Sel, MemRead, MemWrite, MemtoReg, RegWrite,
                   ALUSrcA, ALUSrcB, ALUOp, immediateSel, BranchEQ, BranchNE, instrDone,
                   trap, busErr};

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected control word for one cycle in a given state, written from the state table.
  function automatic outVecT expState(input tbStateT st, input logic [6:0] op,
                                      input logic [2:0] fn, input logic mr, input logic be);
    outVecT e;
    e = '0;
    case (st)
      S_FETCH: begin
        e.MemRead = 1'b1; e.ALUSrcB = 2'b10;
        e.IRWrite = mr;   e.PCWrite = mr;
      end
      S_DECODE: begin
        e.ALUSrcA = 2'b10; e.ALUSrcB = 2'b01;
        e.immSel  = (op == OP_JAL) ? 3'b100 : 3'b010;
      end
      S_EXEC_R:    begin e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b00; e.ALUOp = 3'b010; end
      S_EXEC_I:    begin e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b01; e.ALUOp = 3'b010; end
      S_AUIPC:     begin e.ALUSrcA = 2'b10; e.ALUSrcB = 2'b01; e.immSel = 3'b101; end
      S_ALU_WB:    begin e.RegWrite = 1'b1; e.instrDone = 1'b1; end
      S_MEM_ADDR: begin
        e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b01;
        e.immSel  = (op == OP_STORE) ? 3'b001 : 3'b000;
      end
      S_MEM_RD:    begin e.MemRead = 1'b1; e.HADDR_Sel = 1'b1; end
      S_MEM_WB:    begin e.RegWrite = 1'b1; e.MemtoReg = 1'b1; e.instrDone = 1'b1; end
      S_MEM_WR:    begin e.MemWrite = 1'b1; e.HADDR_Sel = 1'b1; e.instrDone = mr; end
      S_BRANCH: begin
        e.ALUSrcA = 2'b01; e.ALUOp = 3'b001; e.PCSrc = 1'b1; e.instrDone = 1'b1;
        e.BranchEQ = (fn == 3'b000); e.BranchNE = (fn == 3'b001);
      end
      S_JAL, S_JALR_WB: begin
        e.ALUSrcA = 2'b10; e.ALUSrcB = 2'b10; e.RegWrite = 1'b1;
        e.PCWrite = 1'b1;  e.PCSrc = 1'b1;    e.instrDone = 1'b1;
      end
      S_JALR_ADDR: begin e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b01; end
      S_TRAP:      begin e.trap = 1'b1; e.busErr = be; end
      default:     e = '0;
    endcase
    return e;
  endfunction

  // Drive one cycle of inputs, queue its expected outputs, then advance past the next edge.
  task automatic applyStimulus(input string name, input logic rstV, input logic [6:0] op,
                               input logic [2:0] fn, input logic mr, input tbStateT st,
                               input logic be);
    expItemT item;
    rst      = rstV;
    opCode   = op;
    funct    = fn;
    memReady = mr;
    item.name = name;
    item.exp  = expState(st, op, fn, mr, be);
    scoreQ.push_back(item);
    @(posedge clk);
    #1;
  endtask

  // Compare one observed control word against its expectation.
  task automatic checkOutput(input string name, input outVecT act, input outVecT exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever an expectation is pending, check the DUT mid-cycle.
  initial begin
    expItemT item;
    forever begin
      @(negedge clk);
      if (scoreQ.size() > 0) begin
        item = scoreQ.pop_front();
        checkOutput(item.name, actOut, item.exp);
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed instruction sequences with hand-derived per-cycle expectations.
  initial begin
    rst = 1'b0; opCode = OP_R; funct = 3'b000; memReady = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) applyStimulus("reset", 1'b0, OP_R, 3'b000, 1'b1, S_RST, 1'b0);

    applyStimulus("rFetch",  1'b1, OP_R, 3'b000, 1'b1, S_FETCH,  1'b0);
    applyStimulus("rDecode", 1'b1, OP_R, 3'b000, 1'b1, S_DECODE, 1'b0);
    applyStimulus("rExec",   1'b1, OP_R, 3'b000, 1'b1, S_EXEC_R, 1'b0);
    applyStimulus("rWb",     1'b1, OP_R, 3'b000, 1'b1, S_ALU_WB, 1'b0);

    applyStimulus("ldFetch",  1'b1, OP_LOAD, 3'b010, 1'b1, S_FETCH,    1'b0);
    applyStimulus("ldDecode", 1'b1, OP_LOAD, 3'b010, 1'b1, S_DECODE,   1'b0);
    applyStimulus("ldAddr",   1'b1, OP_LOAD, 3'b010, 1'b1, S_MEM_ADDR, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("ldWait", 1'b1, OP_LOAD, 3'b010, 1'b0, S_MEM_RD, 1'b0);
    applyStimulus("ldRead",   1'b1, OP_LOAD, 3'b010, 1'b1, S_MEM_RD,   1'b0);
    applyStimulus("ldWb",     1'b1, OP_LOAD, 3'b010, 1'b1, S_MEM_WB,   1'b0);

    applyStimulus("iFetch",  1'b1, OP_I, 3'b000, 1'b1, S_FETCH,  1'b0);
    applyStimulus("iDecode", 1'b1, OP_I, 3'b000, 1'b1, S_DECODE, 1'b0);
    applyStimulus("iExec",   1'b1, OP_I, 3'b000, 1'b1, S_EXEC_I, 1'b0);
    applyStimulus("iWb",     1'b1, OP_I, 3'b000, 1'b1, S_ALU_WB, 1'b0);

    applyStimulus("auFetch",  1'b1, OP_AUIPC, 3'b000, 1'b1, S_FETCH,  1'b0);
    applyStimulus("auDecode", 1'b1, OP_AUIPC, 3'b000, 1'b1, S_DECODE, 1'b0);
    applyStimulus("auExec",   1'b1, OP_AUIPC, 3'b000, 1'b1, S_AUIPC,  1'b0);
    applyStimulus("auWb",     1'b1, OP_AUIPC, 3'b000, 1'b1, S_ALU_WB, 1'b0);

    applyStimulus("jalFetch",  1'b1, OP_JAL, 3'b000, 1'b1, S_FETCH,  1'b0);
    applyStimulus("jalDecode", 1'b1, OP_JAL, 3'b000, 1'b1, S_DECODE, 1'b0);
    applyStimulus("jalWb",     1'b1, OP_JAL, 3'b000, 1'b1, S_JAL,    1'b0);

    applyStimulus("beqFetch",  1'b1, OP_BRANCH, 3'b000, 1'b1, S_FETCH,  1'b0);
    applyStimulus("beqDecode", 1'b1, OP_BRANCH, 3'b000, 1'b1, S_DECODE, 1'b0);
    applyStimulus("beqBranch", 1'b1, OP_BRANCH, 3'b000, 1'b1, S_BRANCH, 1'b0);

    applyStimulus("bneFetch",  1'b1, OP_BRANCH, 3'b001, 1'b1, S_FETCH,  1'b0);
    applyStimulus("bneDecode", 1'b1, OP_BRANCH, 3'b001, 1'b1, S_DECODE, 1'b0);
    applyStimulus("bneBranch", 1'b1, OP_BRANCH, 3'b001, 1'b1, S_BRANCH, 1'b0);

    for (int i = 0; i < 2; i++) applyStimulus("stFetchWait", 1'b1, OP_STORE, 3'b010, 1'b0, S_FETCH, 1'b0);
    applyStimulus("stFetch",  1'b1, OP_STORE, 3'b010, 1'b1, S_FETCH,    1'b0);
    applyStimulus("stDecode", 1'b1, OP_STORE, 3'b010, 1'b1, S_DECODE,   1'b0);
    applyStimulus("stAddr",   1'b1, OP_STORE, 3'b010, 1'b1, S_MEM_ADDR, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus("stWait", 1'b1, OP_STORE, 3'b010, 1'b0, S_MEM_WR, 1'b0);
    applyStimulus("stLastChance", 1'b1, OP_STORE, 3'b010, 1'b1, S_MEM_WR, 1'b0);
    applyStimulus("stNextFetch",  1'b1, OP_STORE, 3'b010, 1'b1, S_FETCH,  1'b0);

    applyStimulus("bbDecode", 1'b1, OP_BRANCH, 3'b010, 1'b1, S_DECODE, 1'b0);
    applyStimulus("bbTrap",   1'b1, OP_BRANCH, 3'b010, 1'b1, S_TRAP,   1'b0);
    applyStimulus("bbSticky", 1'b1, OP_R,      3'b000, 1'b0, S_TRAP,   1'b0);
    applyStimulus("bbSticky", 1'b1, OP_R,      3'b000, 1'b1, S_TRAP,   1'b0);
    applyStimulus("bbReset",  1'b0, OP_R,      3'b000, 1'b1, S_RST,    1'b0);

    applyStimulus("ilFetch",  1'b1, OP_BAD, 3'b000, 1'b1, S_FETCH,  1'b0);
    applyStimulus("ilDecode", 1'b1, OP_BAD, 3'b000, 1'b1, S_DECODE, 1'b0);
    applyStimulus("ilTrap",   1'b1, OP_BAD, 3'b000, 1'b1, S_TRAP,   1'b0);
    applyStimulus("ilReset",  1'b0, OP_BAD, 3'b000, 1'b1, S_RST,    1'b0);

    applyStimulus("toFetch",  1'b1, OP_STORE, 3'b010, 1'b1, S_FETCH,    1'b0);
    applyStimulus("toDecode", 1'b1, OP_STORE, 3'b010, 1'b1, S_DECODE,   1'b0);
    applyStimulus("toAddr",   1'b1, OP_STORE, 3'b010, 1'b1, S_MEM_ADDR, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus("toWait", 1'b1, OP_STORE, 3'b010, 1'b0, S_MEM_WR, 1'b0);
    applyStimulus("toTrap",   1'b1, OP_STORE, 3'b010, 1'b0, S_TRAP, 1'b1);
    applyStimulus("toSticky", 1'b1, OP_STORE, 3'b010, 1'b1, S_TRAP, 1'b1);
    applyStimulus("toReset",  1'b0, OP_STORE, 3'b010, 1'b1, S_RST,  1'b0);

    applyStimulus("jrFetch",   1'b1, OP_JALR, 3'b000, 1'b1, S_FETCH,     1'b0);
    applyStimulus("jrDecode",  1'b1, OP_JALR, 3'b000, 1'b1, S_DECODE,    1'b0);
    applyStimulus("jrAddr",    1'b1, OP_JALR, 3'b000, 1'b1, S_JALR_ADDR, 1'b0);
    applyStimulus("jrRstWb",   1'b0, OP_JALR, 3'b000, 1'b1, S_RST,       1'b0);
    applyStimulus("jrRefetch", 1'b1, OP_JALR, 3'b000, 1'b1, S_FETCH,     1'b0);
    applyStimulus("jrDecode2", 1'b1, OP_JALR, 3'b000, 1'b1, S_DECODE,    1'b0);
    applyStimulus("jrAddr2",   1'b1, OP_JALR, 3'b000, 1'b1, S_JALR_ADDR, 1'b0);
    applyStimulus("jrWb",      1'b1, OP_JALR, 3'b000, 1'b1, S_JALR_WB,   1'b0);
    applyStimulus("jrDone",    1'b1, OP_R,    3'b000, 1'b1, S_FETCH,     1'b0);

    @(negedge clk);
    #1;
    if (scoreQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", scoreQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised multi-cycle successor to the single-cycle decoder. It sequences each RV32I instruction through fetch, decode, execute, memory and write-back states, driving datapath enables per state. The instruction and data accesses share one memory/UART bus port and use a ready handshake with a timeout.
It sits between the instruction register, the shared-bus address mux and the PC/ALUOut datapath.

Parameters:
ALUOP_W, 3, width of ALUOp.
IMMSEL_W, 3, width of immediateSel.
MEM_TIMEOUT, 255, maximum wait cycles for mem_ready; 0 disables the timeout.
TO_W, 8, width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous reset, active-low (0 = reset).
opCode  in  7  opcode field from the instruction register.
funct  in  3  funct3 from the instruction register.
mem_ready  in  1  bus access complete this cycle.
PCWrite  out  1  load PC.
PCSrc  out  1  0 = ALU result, 1 = ALUOut register.
IRWrite  out  1  load instruction register.
HADDR_Sel  out  1  0 = PC address, 1 = ALUOut address.
MemRead  out  1  bus read request.
MemWrite  out  1  bus write request.
MemtoReg  out  1  write-back source is memory data.
RegWrite  out  1  register file write.
ALUSrcA  out  2  00 = PC, 01 = RD1, 10 = OldPC.
ALUSrcB  out  2  00 = RD2, 01 = imm, 10 = constant 4.
ALUOp  out  ALUOP_W  000 = add, 001 = sub/compare, 010 = decode by funct.
immediateSel  out  IMMSEL_W  000 = I, 001 = S, 010 = B, 100 = J, 101 = U.
BranchEQ  out  1  conditional PC write if zero.
BranchNE  out  1  conditional PC write if not zero.
instr_done  out  1  one-cycle pulse when an instruction completes.
trap  out  1  sticky; illegal instruction or bus timeout.
bus_err  out  1  sticky; trap caused by timeout.

Behaviour:
- Moore FSM with registered state. Outputs are decoded from the state; IRWrite and PCWrite in FETCH are additionally gated by mem_ready.
- Reset (rst==0 at an edge): state=FETCH, wait counter=0, trap and bus_err cleared. While rst==0, every output is forced to 0. Reset in any state, including mid-wait, aborts the instruction.
- Any output not listed for a state is 0.
- FETCH: MemRead=1, HADDR_Sel=0, ALUSrcA=00, ALUSrcB=10, ALUOp=000.
  - When mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=0, go to DECODE.
  - Otherwise hold.
- DECODE: ALUSrcA=10, ALUSrcB=01, ALUOp=000; immediateSel=100 if opCode is JAL, else 010. This precomputes the target into ALUOut. Next state by opCode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH, only if funct is 000 or 001; other funct → TRAP
  - 1101111 → JAL
  - 1100111 → JALR_ADDR
  - 0010111 → AUIPC
  - anything else → TRAP
- EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=010 → ALU_WB.
- EXEC_I: ALUSrcA=01, ALUSrcB=01, ALUOp=010, immediateSel=000 → ALU_WB.
- AUIPC: ALUSrcA=10, ALUSrcB=01, immediateSel=101, ALUOp=000 → ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0, instr_done=1 → FETCH.
- MEM_ADDR: ALUSrcA=01, ALUSrcB=01, ALUOp=000; immediateSel=000 for loads, 001 for stores. Loads → MEM_RD; stores → MEM_WR.
- MEM_RD: MemRead=1, HADDR_Sel=1; holds until mem_ready=1, then → MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, instr_done=1 → FETCH.
- MEM_WR: MemWrite=1, HADDR_Sel=1; holds until mem_ready=1, then instr_done=1 → FETCH.
- BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=001, PCSrc=1; BranchEQ=(funct==000), BranchNE=(funct==001); instr_done=1 → FETCH.
- JAL: ALUSrcA=10, ALUSrcB=10, ALUOp=000, RegWrite=1, PCWrite=1, PCSrc=1, instr_done=1 → FETCH.
- JALR_ADDR: ALUSrcA=01, ALUSrcB=01, immediateSel=000, ALUOp=000 → JALR_WB.
- JALR_WB: same outputs as JAL → FETCH.
- Wait counter:
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
  - When MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT while still waiting, the next state is TRAP with bus_err set. mem_ready=1 in that same cycle wins: normal transition, no trap.
- TRAP: trap=1, all request outputs 0; remains in TRAP until reset.

Optional Feature:
BRANCH_EXT_EN
- Defined: adds outputs BranchLT, BranchGE and BranchUns (1 bit each).
  - funct 100 or 110 asserts BranchLT in BRANCH; funct 101 or 111 asserts BranchGE.
  - BranchUns is asserted for 110 and 111.
  - ALUOp=001 for all of these; none of these funct values trap.
- Undefined: those ports are absent, and funct 010, 011 and 100–111 on opcode 1100011 go to TRAP.

Test Plan:
- Reset: hold rst=0 for 3 cycles with mem_ready=1 → all outputs 0. Release rst → FETCH with MemRead=1, and IRWrite=PCWrite=1 in that same cycle.
- R-type: opCode=0110011, mem_ready=1 → FETCH, DECODE, EXEC_R (ALUOp=010), ALU_WB (RegWrite=1); instr_done pulses once, at cycle 4.
- Load with wait: opCode=0000011, mem_ready low for 3 cycles in MEM_RD → MEM_RD held 4 cycles, then MEM_WB with MemtoReg=1 and RegWrite=1; total 5+3 cycles.
- BNE: opCode=1100011, funct=001 → BRANCH with BranchNE=1, BranchEQ=0, PCSrc=1, ALUOp=001. funct=010 (macro undefined) → trap=1, bus_err=0, sticky.
- Timeout: MEM_TIMEOUT=4, store with mem_ready=0 held → TRAP entered after 5 cycles in MEM_WR, trap=bus_err=1. With mem_ready=1 on the 5th cycle instead, → no trap, FETCH.
- Reset mid-JALR: assert rst=0 in JALR_WB → RegWrite=PCWrite=0 that cycle; next state FETCH, trap cleared.
